// File: rtl/timer_bank_pkg.sv
// Shared register map, control field offsets and prescaler helpers for timer_bank.
package timer_bank_pkg;

    localparam logic [3:0] ADDR_TICKS     = 4'd0;
    localparam logic [3:0] ADDR_CTRL      = 4'd1;
    localparam logic [3:0] ADDR_STAT      = 4'd2;
    localparam logic [3:0] ADDR_CHAN_BASE = 4'd8;

    localparam int EN_LSB    = 0;
    localparam int PER_LSB   = 8;
    localparam int IRQEN_LSB = 16;

    // Prescaler register width; DIV is restricted to below 2**20.
    localparam int PRESC_W = 20;

    function automatic int calc_div(input int clock_freq, input int tick_freq);
        return clock_freq / tick_freq;
    endfunction

endpackage

// File: rtl/timer_chan.sv
// One down-count channel: reload/count registers and the per-tick step with expiry pulse.
module timer_chan
    import timer_bank_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    input  logic                 step,
    input  logic                 periodic,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 expire
);

    logic [CNT_WIDTH-1:0] reload;

    // A bus load in the same cycle as a step wins and suppresses the expiry.
    assign expire = step && !load && (count == CNT_WIDTH'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            reload <= '0;
        end else if (load) begin
            count  <= load_val;
            reload <= load_val;
        end else if (step) begin
            if (count > CNT_WIDTH'(1)) begin
                count <= count - CNT_WIDTH'(1);
            end else if (count == CNT_WIDTH'(1)) begin
                count <= periodic ? reload : '0;
            end
        end
    end

endmodule

// File: rtl/timer_bank.sv
// Free-running tick counter plus NUM_CHAN one-shot/periodic countdown channels on the IO bus.
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int CLOCK_FREQ = 40_000_000,
    parameter int TICK_FREQ  = 1000,
    parameter int NUM_CHAN   = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stb,
    input  logic                we,
    input  logic [3:0]          addr,
    input  logic [31:0]         data_in,
    output logic [31:0]         data_out,
    output logic                ack,
    output logic                tick,
    output logic [NUM_CHAN-1:0] expired,
    output logic                irq
);

    localparam int DIV = calc_div(CLOCK_FREQ, TICK_FREQ);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(DIV - 1);

    logic [PRESC_W-1:0]   presc;
    logic [CNT_WIDTH-1:0] ticks;
    logic [NUM_CHAN-1:0]  en, per, irq_en;
    logic [NUM_CHAN-1:0]  expire, chan_wr, clr;
    logic [CNT_WIDTH-1:0] chan_count [NUM_CHAN];
    logic                 wr, ticks_wr, ctrl_wr, stat_wr, step_ok;
    logic [31:0]          rdata;

    assign wr       = stb & we;
    assign ticks_wr = wr && (addr == ADDR_TICKS);
    assign ctrl_wr  = wr && (addr == ADDR_CTRL);
    assign stat_wr  = wr && (addr == ADDR_STAT);
    assign clr      = stat_wr ? data_in[NUM_CHAN-1:0] : '0;

    assign tick = (presc == PRESC_MAX);
    // A control write swallows the coinciding tick for every channel.
    assign step_ok = tick & ~ctrl_wr;
    assign ack     = stb;
    assign irq     = |(expired & irq_en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ticks <= '0;
        end else if (ticks_wr) begin
            ticks <= data_in[CNT_WIDTH-1:0];
        end else if (tick) begin
            ticks <= ticks + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en     <= '0;
            per    <= '0;
            irq_en <= '0;
        end else if (ctrl_wr) begin
            en     <= data_in[EN_LSB +: NUM_CHAN];
            per    <= data_in[PER_LSB +: NUM_CHAN];
            irq_en <= data_in[IRQEN_LSB +: NUM_CHAN];
        end else begin
            en <= en & ~(expire & ~per);
        end
    end

    // Set has priority over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            expired <= '0;
        end else begin
            expired <= (expired & ~clr) | expire;
        end
    end

    for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
        assign chan_wr[i] = wr && (addr == ADDR_CHAN_BASE + 4'(i));

        timer_chan #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .load     (chan_wr[i]),
            .load_val (data_in[CNT_WIDTH-1:0]),
            .step     (step_ok & en[i]),
            .periodic (per[i]),
            .count    (chan_count[i]),
            .expire   (expire[i])
        );
    end

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_TICKS: rdata = 32'(ticks);
            ADDR_CTRL: begin
                rdata[EN_LSB +: NUM_CHAN]    = en;
                rdata[PER_LSB +: NUM_CHAN]   = per;
                rdata[IRQEN_LSB +: NUM_CHAN] = irq_en;
            end
            ADDR_STAT: rdata[NUM_CHAN-1:0] = expired;
            default: begin
                for (int i = 0; i < NUM_CHAN; i++) begin
                    if (addr == ADDR_CHAN_BASE + 4'(i)) begin
                        rdata = 32'(chan_count[i]);
                    end
                end
            end
        endcase
        data_out = (stb & ~we) ? rdata : '0;
    end

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank with DIV=10: register table plus timed channel scenarios.
module tb_timer_bank;
    import timer_bank_pkg::*;

    localparam int NUM_CHAN = 4;

    typedef struct packed {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stb = 1'b0;
    logic we  = 1'b0;
    logic [3:0]  addr    = 4'd0;
    logic [31:0] data_in = 32'd0;
    logic [31:0] data_out;
    logic        ack, tick, irq;
    logic [NUM_CHAN-1:0] expired;

    int pc;
    int n_checks = 0;
    int n_err    = 0;

    timer_bank #(
        .CLOCK_FREQ(10000),
        .TICK_FREQ (1000),
        .NUM_CHAN  (NUM_CHAN),
        .CNT_WIDTH (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .stb      (stb),
        .we       (we),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .ack      (ack),
        .tick     (tick),
        .expired  (expired),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; tick is due when pc % 10 == 9.
    always @(posedge clk or posedge rst) begin
        if (rst) pc <= 0;
        else     pc <= pc + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, pc=%0d", pc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        stb = 1'b1; we = 1'b1; addr = a; data_in = d;
        @(negedge clk);
        stb = 1'b0; we = 1'b0; data_in = 32'd0;
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string name);
        stb = 1'b1; we = 1'b0; addr = a;
        #1;
        check(name, data_out, exp);
        stb = 1'b0;
    endtask

    task automatic wait_pc(input int target);
        int guard = 0;
        while (pc != target && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (pc != target) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_pc: stuck at pc=%0d, wanted %0d", pc, target);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_flags(input string name, input logic [3:0] exp_flags, input logic exp_irq);
        check({name, "_expired"}, {28'd0, expired}, {28'd0, exp_flags});
        check({name, "_irq"}, {31'd0, irq}, {31'd0, exp_irq});
    endtask

    initial begin
        vec_t vecs [16];

        // Reset state, after a clock edge with rst held high.
        @(negedge clk);
        stb = 1'b1; we = 1'b0; addr = ADDR_TICKS;
        #1;
        check("rst_tick", {31'd0, tick}, 32'd0);
        check("rst_ack", {31'd0, ack}, 32'd1);
        check("rst_data_out", data_out, 32'd0);
        check_flags("rst", 4'b0000, 1'b0);
        stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Prescaler: ticks on the 10th, 20th and 30th edge.
        for (int k = 0; k < 35; k++) begin
            @(negedge clk);
            check($sformatf("tick_pc%0d", pc), {31'd0, tick}, (pc % 10 == 9) ? 32'd1 : 32'd0);
        end
        bus_read(ADDR_TICKS, 32'd3, "ticks_after_35");

        // Register map table; channels have zero counts so nothing expires.
        vecs = '{
            '{1'b0, 4'd1,  32'h0000_0000, 32'h0000_0000},
            '{1'b1, 4'd1,  32'hFFFF_FFFF, 32'h0000_0000},
            '{1'b0, 4'd1,  32'h0000_0000, 32'h000F_0F0F},
            '{1'b1, 4'd1,  32'h0000_0000, 32'h0000_0000},
            '{1'b0, 4'd1,  32'h0000_0000, 32'h0000_0000},
            '{1'b1, 4'd11, 32'h0000_1234, 32'h0000_0000},
            '{1'b0, 4'd11, 32'h0000_0000, 32'h0000_1234},
            '{1'b1, 4'd12, 32'h0000_AAAA, 32'h0000_0000},
            '{1'b0, 4'd12, 32'h0000_0000, 32'h0000_0000},
            '{1'b0, 4'd8,  32'h0000_0000, 32'h0000_0000},
            '{1'b1, 4'd5,  32'h0000_0055, 32'h0000_0000},
            '{1'b0, 4'd5,  32'h0000_0000, 32'h0000_0000},
            '{1'b0, 4'd2,  32'h0000_0000, 32'h0000_0000},
            '{1'b0, 4'd15, 32'h0000_0000, 32'h0000_0000},
            '{1'b1, 4'd11, 32'h0000_0000, 32'h0000_0000},
            '{1'b0, 4'd11, 32'h0000_0000, 32'h0000_0000}
        };
        for (int v = 0; v < 16; v++) begin
            stb = 1'b1; we = vecs[v].we; addr = vecs[v].addr; data_in = vecs[v].wdata;
            #1;
            check($sformatf("vec%0d_ack", v), {31'd0, ack}, 32'd1);
            check($sformatf("vec%0d_data_out", v), data_out, vecs[v].exp);
            if (vecs[v].we) @(negedge clk);
            stb = 1'b0; we = 1'b0; data_in = 32'd0;
            @(negedge clk);
        end

        // One-shot channel 0 with irq: expires on the third tick.
        do_reset();
        bus_write(4'd8, 32'd3);
        bus_write(ADDR_CTRL, 32'h0001_0001);
        wait_pc(29);
        check_flags("os_before", 4'b0000, 1'b0);
        bus_read(4'd8, 32'd1, "os_chan0_before");
        wait_pc(30);
        check_flags("os_after", 4'b0001, 1'b1);
        bus_read(4'd8, 32'd0, "os_chan0_after");
        bus_read(ADDR_CTRL, 32'h0001_0000, "os_ctrl_disabled");
        bus_write(ADDR_STAT, 32'h1);
        check_flags("os_cleared", 4'b0000, 1'b0);
        wait_pc(41);
        check_flags("os_no_repeat", 4'b0000, 1'b0);

        // Periodic channel 1 reloading 2: expires every second tick.
        do_reset();
        bus_write(4'd9, 32'd2);
        bus_write(ADDR_CTRL, 32'h0000_0202);
        for (int k = 1; k <= 3; k++) begin
            wait_pc(20 * k - 1);
            check_flags($sformatf("per%0d_before", k), 4'b0000, 1'b0);
            wait_pc(20 * k);
            check_flags($sformatf("per%0d_set", k), 4'b0010, 1'b0);
            bus_read(4'd9, 32'd2, $sformatf("per%0d_chan1", k));
            bus_write(ADDR_STAT, 32'h2);
            check_flags($sformatf("per%0d_clr", k), 4'b0000, 1'b0);
        end

        // Status clear coinciding with the expiry: set wins.
        do_reset();
        bus_write(4'd8, 32'd1);
        bus_write(ADDR_CTRL, 32'h0001_0001);
        wait_pc(9);
        bus_write(ADDR_STAT, 32'h1);
        check_flags("setclr", 4'b0001, 1'b1);

        // Channel write on a tick while count==1, then control write on a tick.
        do_reset();
        bus_write(4'd10, 32'd2);
        bus_write(ADDR_CTRL, 32'h0000_0004);
        wait_pc(19);
        bus_read(4'd10, 32'd1, "cw_chan2_before");
        bus_write(4'd10, 32'd5);
        check_flags("cw_no_expiry", 4'b0000, 1'b0);
        bus_read(4'd10, 32'd5, "cw_chan2_loaded");
        wait_pc(30);
        bus_read(4'd10, 32'd4, "cw_chan2_step");
        wait_pc(39);
        bus_write(ADDR_CTRL, 32'h0000_0004);
        bus_read(4'd10, 32'd4, "ctrlw_tick_ignored");
        wait_pc(50);
        bus_read(4'd10, 32'd3, "ctrlw_next_tick");

        // Tick counter wrap, write-over-tick, then asynchronous reset.
        do_reset();
        bus_write(ADDR_TICKS, 32'hFFFF_FFFF);
        bus_read(ADDR_TICKS, 32'hFFFF_FFFF, "ticks_loaded");
        wait_pc(10);
        bus_read(ADDR_TICKS, 32'd0, "ticks_wrapped");
        wait_pc(19);
        bus_write(ADDR_TICKS, 32'h100);
        bus_read(ADDR_TICKS, 32'h100, "ticks_write_wins");
        bus_write(4'd8, 32'd1);
        bus_write(ADDR_CTRL, 32'h0001_0101);
        wait_pc(30);
        check_flags("pre_rst", 4'b0001, 1'b1);
        bus_read(ADDR_TICKS, 32'h101, "ticks_after_tick");
        wait_pc(39);
        check("pre_rst_tick", {31'd0, tick}, 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_tick", {31'd0, tick}, 32'd0);
        check_flags("async_rst", 4'b0000, 1'b0);
        bus_read(ADDR_TICKS, 32'd0, "async_rst_ticks");
        bus_read(ADDR_CTRL, 32'd0, "async_rst_ctrl");
        @(negedge clk);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
